digest_unpacker: RTL and testbench

//  Return path of the SHA-256 UART link. Captures the digest from the SHA-256 core and serializes it
//  MSB-first into a byte-wide UART transmitter, one byte per transmitter handshake.

---
 rtl/sha_uart_pkg.sv | 24 ++
 rtl/digest_unpacker_nibble_to_ascii.sv | 12 +
 rtl/digest_unpacker.sv | 101 ++++++++++
 tb/tb_digest_unpacker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_uart_pkg.sv
// Shared definitions for the SHA-256 UART link: unpacker FSM encoding,
// ASCII constants and the nibble-to-hex helper.
package sha_uart_pkg;

    localparam int SHA_DIGEST_W = 256;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h57;  // 'a' - 10

    typedef enum logic [1:0] {
        UNP_IDLE   = 2'd0,
        UNP_ISSUE  = 2'd1,
        UNP_WAIT   = 2'd2,
        UNP_FINISH = 2'd3
    } unp_state_e;

    // Lowercase hex character for one nibble
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (ASCII_A_OFS + {4'd0, n});
    endfunction

endpackage

// File: rtl/digest_unpacker_nibble_to_ascii.sv
// Combinational nibble -> lowercase hex ASCII character. Also used by
// the debug dump logic, hence a standalone module.
module nibble_to_ascii
    import sha_uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nib2ascii(nibble);

endmodule

// File: rtl/digest_unpacker.sv
// Serializes a captured SHA-256 digest MSB-first into a byte-wide UART
// transmitter, optionally as lowercase hex text with a CR/LF trailer.
module digest_unpacker
    import sha_uart_pkg::*;
#(
    parameter int DIGEST_WIDTH   = SHA_DIGEST_W,
    parameter int HEX_ASCII      = 0,
    parameter int APPEND_NEWLINE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIGEST_WIDTH-1:0] digest_in,
    input  logic                    digest_valid,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    output logic                    busy,
    output logic                    send_done,
    output logic                    overrun
);

    localparam int N_DATA  = (HEX_ASCII != 0) ? DIGEST_WIDTH / 4 : DIGEST_WIDTH / 8;
    localparam int N_TOTAL = N_DATA + 2 * APPEND_NEWLINE;
    localparam int CW      = $clog2(N_TOTAL + 1);
    localparam int SHIFT   = (HEX_ASCII != 0) ? 4 : 8;

    localparam logic [CW-1:0] N_DATA_C = CW'(N_DATA);
    localparam logic [CW-1:0] LAST_C   = CW'(N_TOTAL - 1);

    unp_state_e              state;
    logic [DIGEST_WIDTH-1:0] shift_r;
    logic [CW-1:0]           cnt;
    logic [7:0]              hex_char;
    logic [7:0]              sym;

    nibble_to_ascii u_nib (
        .nibble (shift_r[DIGEST_WIDTH-1 -: 4]),
        .ascii  (hex_char)
    );

    // Current symbol: digest data until N_DATA symbols are out, then CR, LF
    always_comb begin
        sym = (HEX_ASCII != 0) ? hex_char : shift_r[DIGEST_WIDTH-1 -: 8];
        if (cnt >= N_DATA_C)
            sym = (cnt == N_DATA_C) ? ASCII_CR : ASCII_LF;
    end

    // Transfer FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNP_IDLE;
            shift_r   <= '0;
            cnt       <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= 8'h00;
            busy      <= 1'b0;
            send_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_dv     <= 1'b0;
            send_done <= 1'b0;
            // Any digest offered outside IDLE is dropped and flagged
            overrun   <= digest_valid && (state != UNP_IDLE);
            case (state)
                UNP_IDLE: begin
                    if (digest_valid) begin
                        shift_r <= digest_in;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= UNP_ISSUE;
                    end
                end
                UNP_ISSUE: begin
                    if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= sym;
                        state   <= UNP_WAIT;
                    end
                end
                UNP_WAIT: begin
                    // A tx_done coincident with our own tx_dv belongs to an
                    // earlier byte and must not advance the stream
                    if (tx_done && !tx_dv) begin
                        cnt <= cnt + CW'(1);
                        if (cnt < N_DATA_C)
                            shift_r <= shift_r << SHIFT;
                        state <= (cnt == LAST_C) ? UNP_FINISH : UNP_ISSUE;
                    end
                end
                UNP_FINISH: begin
                    send_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= UNP_IDLE;
                end
                default: state <= UNP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_unpacker.sv
// Scoreboard bench: a raw-mode and a hex+CR/LF instance, each with its own
// UART model; expected byte streams are derived from the digest value.
module tb_digest_unpacker;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk, rst;
    logic [255:0] din;
    logic         dv_r, dv_h;
    logic         uact_r, udone_r, uact_h, udone_h;
    logic         hold, spur;
    logic         txdv_r, busy_r, sd_r, ov_r;
    logic         txdv_h, busy_h, sd_h, ov_h;
    logic [7:0]   txb_r, txb_h;

    int cyc = 0;
    int checks = 0, errors = 0;
    int dly_r = 10;
    int dvcnt_r = 0, dvcnt_h = 0, sdcnt_r = 0, sdcnt_h = 0, ovcnt_r = 0, ovcnt_h = 0;
    int chk_first_r = 0, exp_first_r = 0;
    logic prev_busy_r = 0, prev_busy_h = 0;
    logic [7:0] q_r[$];
    logic [7:0] q_h[$];

    digest_unpacker dut_raw (
        .clk(clk), .rst(rst), .digest_in(din), .digest_valid(dv_r),
        .tx_active(uact_r | hold), .tx_done(udone_r | spur),
        .tx_dv(txdv_r), .tx_byte(txb_r), .busy(busy_r),
        .send_done(sd_r), .overrun(ov_r)
    );

    digest_unpacker #(.HEX_ASCII(1), .APPEND_NEWLINE(1)) dut_hex (
        .clk(clk), .rst(rst), .digest_in(din), .digest_valid(dv_h),
        .tx_active(uact_h), .tx_done(udone_h),
        .tx_dv(txdv_h), .tx_byte(txb_h), .busy(busy_h),
        .send_done(sd_h), .overrun(ov_h)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 10) ? 8'd48 + 8'(n) : 8'd97 + 8'(n) - 8'd10;
    endfunction

    task automatic push_raw(input logic [255:0] d);
        for (int i = 0; i < 32; i++) q_r.push_back(d[255-8*i -: 8]);
    endtask

    task automatic push_hex(input logic [255:0] d);
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            b = d[255-8*i -: 8];
            q_h.push_back(hexc(b[7:4]));
            q_h.push_back(hexc(b[3:0]));
        end
        q_h.push_back(8'h0D);
        q_h.push_back(8'h0A);
    endtask

    // UART TX models: busy from tx_dv until a one-cycle tx_done
    initial begin
        uact_r = 0; udone_r = 0;
        forever begin
            @(negedge clk);
            udone_r = 0;
            if (txdv_r && !uact_r) begin
                uact_r = 1;
                repeat (dly_r - 1) @(negedge clk);
                udone_r = 1;
                uact_r = 0;
            end
        end
    end

    initial begin
        uact_h = 0; udone_h = 0;
        forever begin
            @(negedge clk);
            udone_h = 0;
            if (txdv_h && !uact_h) begin
                uact_h = 1;
                repeat (9) @(negedge clk);
                udone_h = 1;
                uact_h = 0;
            end
        end
    end

    // Monitors: pop and compare each issued byte; check the end of transfer
    always @(negedge clk) begin
        if (txdv_r) begin
            dvcnt_r++;
            if (q_r.size() == 0) chk("raw_unexpected_byte", {56'd0, txb_r}, 64'hFFFF);
            else chk("raw_byte", {56'd0, txb_r}, {56'd0, q_r.pop_front()});
            if (chk_first_r != 0) begin
                chk("raw_first_dv_cycle", 64'(cyc), 64'(exp_first_r));
                chk_first_r = 0;
            end
        end
        if (sd_r) begin
            sdcnt_r++;
            chk("raw_busy_falls_with_send_done", {62'd0, prev_busy_r, busy_r}, 64'd2);
            chk("raw_all_bytes_sent", 64'(q_r.size()), 64'd0);
        end
        if (ov_r) ovcnt_r++;
        prev_busy_r = busy_r;
    end

    always @(negedge clk) begin
        if (txdv_h) begin
            dvcnt_h++;
            if (q_h.size() == 0) chk("hex_unexpected_byte", {56'd0, txb_h}, 64'hFFFF);
            else chk("hex_byte", {56'd0, txb_h}, {56'd0, q_h.pop_front()});
        end
        if (sd_h) begin
            sdcnt_h++;
            chk("hex_busy_falls_with_send_done", {62'd0, prev_busy_h, busy_h}, 64'd2);
            chk("hex_all_bytes_sent", 64'(q_h.size()), 64'd0);
        end
        if (ov_h) ovcnt_h++;
        prev_busy_h = busy_h;
    end

    // Bounded wait on a monitor counter: 0=raw send_done, 1=hex send_done, 2=raw tx_dv
    task automatic wait_cnt(input int sel, input int target, input int limit, input string name);
        int v;
        for (int i = 0; i < limit; i++) begin
            v = (sel == 0) ? sdcnt_r : (sel == 1) ? sdcnt_h : dvcnt_r;
            if (v >= target) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Called at a negedge; offers a digest to the raw instance
    task automatic cap_raw(input logic [255:0] d, input logic expect_fresh);
        din = d;
        if (expect_fresh) push_raw(d);
        dv_r = 1;
        @(negedge clk);
        dv_r = 0;
        chk("raw_busy_after_capture", {63'd0, busy_r}, 64'd1);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int base, ov0, dv0, r;
        logic [255:0] d;
        rst = 1; dv_r = 0; dv_h = 0; din = '0; hold = 0; spur = 0;

        // Reset with a coincident digest_valid: nothing captured
        @(negedge clk);
        din = ABC; dv_r = 1; dv_h = 1;
        repeat (2) @(negedge clk);
        dv_r = 0; dv_h = 0;
        chk("rst_busy", {63'd0, busy_r}, 64'd0);
        chk("rst_tx_dv", {63'd0, txdv_r}, 64'd0);
        chk("rst_tx_byte", {56'd0, txb_r}, 64'd0);
        chk("rst_send_done", {63'd0, sd_r}, 64'd0);
        chk("rst_overrun", {63'd0, ov_r}, 64'd0);
        chk("rst_hex_busy", {63'd0, busy_h}, 64'd0);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("rst_dv_not_captured", {63'd0, busy_r | busy_h}, 64'd0);
        chk("rst_no_tx", 64'(dvcnt_r + dvcnt_h), 64'd0);

        // Raw and hex+CRLF transfers of digest("abc") with first-byte latency
        din = ABC;
        push_raw(ABC); push_hex(ABC);
        exp_first_r = cyc + 2; chk_first_r = 1;
        dv_r = 1; dv_h = 1;
        @(negedge clk);
        dv_r = 0; dv_h = 0;
        wait_cnt(0, 1, 2000, "abc_raw");
        wait_cnt(1, 1, 2000, "abc_hex");
        chk("abc_raw_byte_count", 64'(dvcnt_r), 64'd32);
        chk("abc_hex_byte_count", 64'(dvcnt_h), 64'd66);
        chk("abc_send_done_count", 64'(sdcnt_r + sdcnt_h), 64'd2);

        // Spurious tx_done in IDLE, then tx_active held for 50 cycles at capture
        @(negedge clk);
        dv0 = dvcnt_r;
        spur = 1; @(negedge clk); spur = 0;
        repeat (4) @(negedge clk);
        chk("idle_spurious_done_no_tx", 64'(dvcnt_r), 64'(dv0));
        hold = 1;
        exp_first_r = -1; chk_first_r = 1;
        cap_raw(rnd256(), 1);
        repeat (49) @(negedge clk);
        r = cyc;
        hold = 0;
        exp_first_r = r + 1;
        wait_cnt(0, 2, 2000, "hold");

        // Second digest_valid at byte 5; digest_in churns after capture
        @(negedge clk);
        ov0 = ovcnt_r; base = dvcnt_r;
        cap_raw(rnd256(), 1);
        wait_cnt(2, base + 5, 500, "ovr_byte5");
        din = rnd256(); dv_r = 1;
        @(negedge clk);
        dv_r = 0;
        for (int i = 0; i < 20; i++) begin din = rnd256(); @(negedge clk); end
        wait_cnt(0, 3, 2000, "ovr");
        chk("overrun_once", 64'(ovcnt_r - ov0), 64'd1);

        // Reset in WAIT at byte 10, then a fresh transfer from byte 0
        @(negedge clk);
        base = dvcnt_r;
        cap_raw(rnd256(), 1);
        wait_cnt(2, base + 11, 500, "rst_byte10");
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_busy", {63'd0, busy_r}, 64'd0);
        chk("midrst_tx_dv", {63'd0, txdv_r}, 64'd0);
        q_r.delete();
        base = dvcnt_r; base = sdcnt_r;
        repeat (20) @(negedge clk);
        chk("midrst_no_more_tx", {63'd0, busy_r}, 64'd0);
        cap_raw(ABC, 1);
        wait_cnt(0, base + 1, 2000, "after_rst");

        // digest_valid the cycle right after send_done: accepted, no overrun
        @(negedge clk);
        ov0 = ovcnt_r;
        cap_raw(rnd256(), 1);
        wait_cnt(0, base + 2, 2000, "b2b_first");
        @(negedge clk);
        cap_raw(rnd256(), 1);
        wait_cnt(0, base + 3, 2000, "b2b_second");
        chk("b2b_no_overrun", 64'(ovcnt_r - ov0), 64'd0);

        // Random digests with random UART timing
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dly_r = $urandom_range(2, 12);
            cap_raw(rnd256(), 1);
            wait_cnt(0, base + 4 + k, 2000, "rand_raw");
        end
        @(negedge clk);
        d = rnd256();
        din = d; push_hex(d); dv_h = 1;
        @(negedge clk);
        dv_h = 0;
        wait_cnt(1, 2, 2000, "rand_hex");
        chk("hex_no_overrun", 64'(ovcnt_h), 64'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
